// File: rtl/tspi_tx_feed_if.sv
// tspi_tx_feed_if: host write port, status and transmitter byte handshake of tspi_tx_feed
interface tspi_tx_feed_if #(parameter int DW = 8, parameter int AW = 4);
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          flush;
  logic          clr_ovf;
  logic          wr_full;
  logic [AW:0]   level;
  logic [AW:0]   frames;
  logic          ovf;
  logic          busy;
  logic          tx_idle;
  logic          tx_dreq;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  modport master (
    output wr_en, wr_data, wr_last, flush, clr_ovf, tx_idle, tx_dreq,
    input  wr_full, level, frames, ovf, busy, tx_valid, tx_data
  );
  modport slave (
    input  wr_en, wr_data, wr_last, flush, clr_ovf, tx_idle, tx_dreq,
    output wr_full, level, frames, ovf, busy, tx_valid, tx_data
  );
endinterface

// File: rtl/tspi_tx_feed.sv
// tspi_tx_feed: frame-buffering FIFO feeding an SPI transmitter; clk/rst plus bus (host write/status, tx byte handshake)
module tspi_tx_feed #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input logic         clk,
  input logic         rst,
  tspi_tx_feed_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SEND, STREAM, DRAIN_LO, DRAIN_HI} state_t;
  state_t state, state_n;
  logic [DW:0]   mem [2**AW];
  logic [AW:0]   wr_cnt, rd_cnt, frames_q, level;
  logic [DW-1:0] data_q;
  logic [DW:0]   head;
  logic          ovf_q, push, pop, clr;
  assign level = wr_cnt - rd_cnt;
  assign head  = mem[rd_cnt[AW-1:0]];
  assign push  = bus.wr_en && !level[AW];
  assign pop   = state == SEND;
  assign clr   = state == IDLE && bus.flush;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = !bus.flush && frames_q != '0 && bus.tx_idle ? SEND : IDLE;
      SEND:     state_n = head[DW] ? DRAIN_LO : STREAM;
      STREAM:   state_n = bus.tx_dreq ? SEND : STREAM;
      DRAIN_LO: state_n = !bus.tx_idle ? DRAIN_HI : DRAIN_LO;
      DRAIN_HI: state_n = bus.tx_idle ? IDLE : DRAIN_HI;
      default:  state_n = IDLE;
    endcase
  end
  always_comb begin
    bus.tx_valid = pop;
    bus.tx_data  = pop ? head[DW-1:0] : data_q;
    bus.busy     = state != IDLE;
    bus.wr_full  = level[AW];
    bus.level    = level;
    bus.frames   = frames_q;
    bus.ovf      = ovf_q;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_cnt[AW-1:0]] <= {bus.wr_last, bus.wr_data};
  always_ff @(posedge clk)
    if (rst || clr) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      frames_q <= '0;
    end else begin
      wr_cnt   <= wr_cnt + (AW+1)'(push);
      rd_cnt   <= rd_cnt + (AW+1)'(pop);
      frames_q <= frames_q + (AW+1)'(push && bus.wr_last) - (AW+1)'(pop && head[DW]);
    end
  // tx_data holds the last sent byte between pulses; a dropped write beats clr_ovf
  always_ff @(posedge clk)
    if (rst) begin
      ovf_q  <= 1'b0;
      data_q <= '0;
    end else begin
      ovf_q <= (bus.wr_en && level[AW]) || (ovf_q && !bus.clr_ovf);
      if (pop) data_q <= head[DW-1:0];
    end
endmodule

// File: tb/tb_tspi_tx_feed.sv
// tb_tspi_tx_feed: directed and random checks of tspi_tx_feed against a queue-based reference model
module tb_tspi_tx_feed;
  localparam int DEPTH = 16;
  localparam int P_WAIT = 0, P_SEND = 1, P_BURST = 2, P_LOW = 3, P_HIGH = 4;
  logic clk = 0, rst = 1;
  int vectors = 0, errs = 0;
  bit live = 0;
  logic i_rst = 1, i_wr = 0, i_wl = 0, i_fl = 0, i_co = 0, i_idle = 0, i_dreq = 0;
  logic [7:0] i_wd = 0;
  logic [8:0] q[$];
  int m_ph = P_WAIT;
  logic m_ovf = 0;
  logic [7:0] m_txd = 0;
  int lat, cnt;
  logic [7:0] fd;
  tspi_tx_feed_if #(.DW(8), .AW(4)) bus ();
  tspi_tx_feed #(.DW(8), .AW(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int nlast();
    int n = 0;
    foreach (q[i]) n += int'(q[i][8]);
    return n;
  endfunction
  task automatic check_model();
    chk("tx_valid", {31'b0, bus.tx_valid}, {31'b0, m_ph == P_SEND});
    chk("tx_data", {24'b0, bus.tx_data}, {24'b0, (m_ph == P_SEND && q.size() > 0) ? q[0][7:0] : m_txd});
    chk("level", {27'b0, bus.level}, q.size());
    chk("frames", {27'b0, bus.frames}, nlast());
    chk("wr_full", {31'b0, bus.wr_full}, {31'b0, q.size() == DEPTH});
    chk("ovf", {31'b0, bus.ovf}, {31'b0, m_ovf});
    chk("busy", {31'b0, bus.busy}, {31'b0, m_ph != P_WAIT});
  endtask
  task automatic model_update();
    bit full;
    int nph;
    logic [8:0] b;
    if (i_rst) begin
      q.delete();
      m_ovf = 0;
      m_ph = P_WAIT;
      m_txd = 0;
    end else begin
      full = q.size() == DEPTH;
      nph = m_ph;
      case (m_ph)
        P_WAIT: if (i_fl) q.delete(); else if (nlast() > 0 && i_idle) nph = P_SEND;
        P_SEND: begin
          chk("pop_nonempty", q.size(), q.size() == 0 ? 1 : q.size());
          b = q.pop_front();
          m_txd = b[7:0];
          nph = b[8] ? P_LOW : P_BURST;
        end
        P_BURST: if (i_dreq) nph = P_SEND;
        P_LOW: if (!i_idle) nph = P_HIGH;
        P_HIGH: if (i_idle) nph = P_WAIT;
        default: nph = P_WAIT;
      endcase
      if (i_wr && !full && !(m_ph == P_WAIT && i_fl)) q.push_back({i_wl, i_wd});
      m_ovf = (i_wr && full) || (m_ovf && !i_co);
      m_ph = nph;
    end
  endtask
  task automatic step();
    @(negedge clk);
    if (live) check_model();
    rst = i_rst;
    bus.wr_en = i_wr;
    bus.wr_data = i_wd;
    bus.wr_last = i_wl;
    bus.flush = i_fl;
    bus.clr_ovf = i_co;
    bus.tx_idle = i_idle;
    bus.tx_dreq = i_dreq;
    model_update();
  endtask
  task automatic wr(input logic [7:0] d, input logic l);
    i_wr = 1;
    i_wd = d;
    i_wl = l;
    step();
    i_wr = 0;
    i_wl = 0;
  endtask
  task automatic xmit(input int n, input bit more, output int lat_o, output logic [7:0] fd_o);
    int got = 0, t = 0, extra = 0;
    bit arm = 0;
    lat_o = 0;
    fd_o = 0;
    i_idle = 1;
    i_dreq = 0;
    while (got < n && t < 300) begin
      step();
      t++;
      if (bus.tx_valid) begin
        got++;
        if (lat_o == 0) begin
          lat_o = t;
          fd_o = bus.tx_data;
        end
        i_idle = 0;
        arm = 1;
        i_dreq = 0;
      end else if (arm) begin
        i_dreq = 1;
        arm = 0;
      end else i_dreq = 0;
    end
    chk("xmit_count", got, n);
    i_idle = 0;
    i_dreq = 1;
    step();
    i_dreq = 0;
    extra += int'(bus.tx_valid);
    step();
    extra += int'(bus.tx_valid);
    step();
    extra += int'(bus.tx_valid);
    i_idle = 1;
    if (!more) begin
      repeat (3) begin
        step();
        extra += int'(bus.tx_valid);
      end
      chk("xmit_idle_busy", {31'b0, bus.busy}, 0);
    end
    chk("xmit_extra", extra, 0);
  endtask
  initial begin
    bus.wr_en = 0; bus.wr_data = 0; bus.wr_last = 0; bus.flush = 0;
    bus.clr_ovf = 0; bus.tx_idle = 0; bus.tx_dreq = 0;
    step();
    live = 1;
    step();
    i_rst = 0;
    step();
    chk("rst_valid", {31'b0, bus.tx_valid}, 0);
    chk("rst_data", {24'b0, bus.tx_data}, 0);
    chk("rst_level", {27'b0, bus.level}, 0);
    chk("rst_full", {31'b0, bus.wr_full}, 0);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    i_idle = 1;
    wr(8'hA5, 0);
    wr(8'h3C, 1);
    xmit(2, 0, lat, fd);
    chk("basic_lat", lat, 2);
    chk("basic_first", {24'b0, fd}, 32'hA5);
    i_idle = 0;
    for (int i = 0; i < 16; i++) wr(8'(8'h40 + i), i == 15);
    wr(8'hFF, 0);
    step();
    chk("full_flag", {31'b0, bus.wr_full}, 1);
    chk("full_ovf", {31'b0, bus.ovf}, 1);
    chk("full_level", {27'b0, bus.level}, 16);
    i_co = 1;
    step();
    i_co = 0;
    step();
    chk("ovf_cleared", {31'b0, bus.ovf}, 0);
    xmit(16, 0, lat, fd);
    chk("full_first", {24'b0, fd}, 32'h40);
    i_idle = 0;
    wr(8'h11, 1);
    wr(8'h22, 1);
    step();
    chk("b2b_frames", {27'b0, bus.frames}, 2);
    xmit(1, 1, lat, fd);
    chk("b2b_first", {24'b0, fd}, 32'h11);
    xmit(1, 0, lat, fd);
    chk("b2b_lat", lat, 3);
    chk("b2b_second", {24'b0, fd}, 32'h22);
    i_idle = 1;
    wr(8'h77, 1);
    step();
    wr(8'h88, 1);
    step();
    chk("same_frames", {27'b0, bus.frames}, 1);
    chk("same_level", {27'b0, bus.level}, 1);
    i_idle = 0;
    step();
    step();
    xmit(1, 0, lat, fd);
    chk("same_next", {24'b0, fd}, 32'h88);
    i_idle = 0;
    for (int i = 0; i < 4; i++) wr(8'(8'hD1 + i), i == 3);
    i_idle = 1;
    cnt = 0;
    while (!bus.tx_valid && cnt < 10) begin
      step();
      cnt++;
    end
    chk("stream_start", {31'b0, bus.tx_valid}, 1);
    i_idle = 0;
    i_fl = 1;
    step();
    step();
    i_fl = 0;
    step();
    chk("stream_flush_level", {27'b0, bus.level}, 3);
    chk("stream_busy", {31'b0, bus.busy}, 1);
    i_rst = 1;
    step();
    i_rst = 0;
    step();
    chk("midrst_level", {27'b0, bus.level}, 0);
    chk("midrst_busy", {31'b0, bus.busy}, 0);
    i_idle = 1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      i_dreq = i[0];
      step();
      cnt += int'(bus.tx_valid);
    end
    i_dreq = 0;
    chk("midrst_silent", cnt, 0);
    i_idle = 0;
    for (int i = 0; i < 5; i++) wr(8'(8'hE1 + i), i == 4);
    step();
    chk("flush_pre_level", {27'b0, bus.level}, 5);
    i_fl = 1;
    step();
    i_fl = 0;
    step();
    chk("flush_level", {27'b0, bus.level}, 0);
    chk("flush_frames", {27'b0, bus.frames}, 0);
    i_idle = 1;
    cnt = 0;
    repeat (5) begin
      step();
      cnt += int'(bus.tx_valid);
    end
    chk("flush_silent", cnt, 0);
    for (int i = 0; i < 3000; i++) begin
      i_rst = $urandom_range(0, 299) == 0;
      i_wr = $urandom_range(0, 1);
      i_wd = 8'($urandom);
      i_wl = $urandom_range(0, 3) == 0;
      i_fl = $urandom_range(0, 31) == 0;
      i_co = $urandom_range(0, 19) == 0;
      i_idle = $urandom_range(0, 1);
      i_dreq = $urandom_range(0, 1);
      step();
    end
    i_rst = 0; i_wr = 0; i_fl = 0; i_co = 0; i_dreq = 0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
